// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory and feeds {inst, pc, bubble} to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        bubble_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_r, pc_next;
    logic [31:0] hold_r, hold_next;
    logic [31:0] drain_addr_r, drain_addr_next;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= FETCH;
            pc_r         <= RESET_PC;
            hold_r       <= 32'd0;
            drain_addr_r <= 32'd0;
        end else begin
            state        <= state_next;
            pc_r         <= pc_next;
            hold_r       <= hold_next;
            drain_addr_r <= drain_addr_next;
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc_r;
        hold_next       = hold_r;
        drain_addr_next = drain_addr_r;
        imem_req_o      = 1'b1;
        imem_addr_o     = pc_r;
        inst_o          = 32'd0;
        pc_o            = 32'd0;
        bubble_o        = 1'b1;

        unique case (state)
            FETCH: begin
                inst_o   = imem_data_i;
                pc_o     = pc_r;
                bubble_o = !imem_ready_i || branch_i;
                if (branch_i) begin
                    pc_next = branch_target_i;
                    // An unfinished request must still complete before the new one issues.
                    if (!imem_ready_i) begin
                        state_next      = DRAIN;
                        drain_addr_next = pc_r;
                    end
                end else if (imem_ready_i && !stall_i) begin
                    pc_next = pc_r + PC_STEP;
                end else if (imem_ready_i && stall_i) begin
                    hold_next  = imem_data_i;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                imem_req_o = 1'b0;
                inst_o     = hold_r;
                pc_o       = pc_r;
                bubble_o   = branch_i;
                if (branch_i) begin
                    pc_next    = branch_target_i;
                    state_next = FETCH;
                end else if (!stall_i) begin
                    pc_next    = pc_r + PC_STEP;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                imem_addr_o = drain_addr_r;
                if (branch_i) begin
                    pc_next = branch_target_i;
                end
                if (imem_ready_i) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // Reset forces the IF/ID-facing outputs regardless of the registered state.
        if (!rst_i) begin
            imem_req_o = 1'b0;
            inst_o     = 32'd0;
            pc_o       = 32'd0;
            bubble_o   = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each step drives inputs, queues the expected
// outputs, then pops and compares them mid-cycle before the next clock edge.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        bubble_o;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        bubble;
        logic [31:0] inst;
        logic [31:0] pc;
    } expect_t;

    expect_t exp_q[$];
    int      n_checks = 0;
    int      n_passed = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ready_i   (imem_ready_i),
        .imem_data_i    (imem_data_i),
        .inst_o         (inst_o),
        .pc_o           (pc_o),
        .bubble_o       (bubble_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_passed++;
        else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
    endtask

    // One clock cycle: drive, queue expectation, compare mid-cycle, advance past the edge.
    task automatic step(input logic rst, input logic stall, input logic br,
                        input logic [31:0] tgt, input logic rdy, input logic [31:0] data,
                        input logic e_req, input logic [31:0] e_addr, input logic e_bub,
                        input logic [31:0] e_inst, input logic [31:0] e_pc);
        expect_t e;
        rst_i           = rst;
        stall_i         = stall;
        branch_i        = br;
        branch_target_i = tgt;
        imem_ready_i    = rdy;
        imem_data_i     = data;
        exp_q.push_back('{e_req, e_addr, e_bub, e_inst, e_pc});
        #3;
        e = exp_q.pop_front();
        check32("req",    {31'd0, imem_req_o}, {31'd0, e.req});
        check32("addr",   imem_addr_o,         e.addr);
        check32("bubble", {31'd0, bubble_o},   {31'd0, e.bubble});
        check32("inst",   inst_o,              e.inst);
        check32("pc",     pc_o,                e.pc);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // reset state
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h1111, 0, 32'h0, 1, 32'h0, 32'h0);

        // zero-wait streaming: 0,4,8,C
        step(1, 0, 0, 0, 1, 32'hA000_0000, 1, 32'h0, 0, 32'hA000_0000, 32'h0);
        step(1, 0, 0, 0, 1, 32'hA000_0004, 1, 32'h4, 0, 32'hA000_0004, 32'h4);
        step(1, 0, 0, 0, 1, 32'hA000_0008, 1, 32'h8, 0, 32'hA000_0008, 32'h8);
        step(1, 0, 0, 0, 1, 32'hA000_000C, 1, 32'hC, 0, 32'hA000_000C, 32'hC);

        // stall for 3 cycles while 0x10 returns
        step(1, 1, 0, 0, 1, 32'h00A0_0093, 1, 32'h10, 0, 32'h00A0_0093, 32'h10);
        step(1, 1, 0, 0, 0, 32'h0, 0, 32'h10, 0, 32'h00A0_0093, 32'h10);
        step(1, 1, 0, 0, 0, 32'h0, 0, 32'h10, 0, 32'h00A0_0093, 32'h10);
        step(1, 0, 0, 0, 0, 32'h0, 0, 32'h10, 0, 32'h00A0_0093, 32'h10);

        // two wait cycles then DEADBEEF at 0x14
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h14, 1, 32'h0, 32'h14);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h14, 1, 32'h0, 32'h14);
        step(1, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 32'h14, 0, 32'hDEAD_BEEF, 32'h14);
        step(1, 0, 0, 0, 1, 32'h18, 1, 32'h18, 0, 32'h18, 32'h18);
        step(1, 0, 0, 0, 1, 32'h1C, 1, 32'h1C, 0, 32'h1C, 32'h1C);

        // redirect to 0x100 while 0x20 is outstanding
        step(1, 0, 1, 32'h100, 0, 32'h0, 1, 32'h20, 1, 32'h0, 32'h20);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h20, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h0BAD, 1, 32'h20, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h100, 1, 32'h0, 32'h100);

        // branch and stall together in HOLD
        step(1, 1, 0, 0, 1, 32'hD5D5_D5D5, 1, 32'h100, 0, 32'hD5D5_D5D5, 32'h100);
        step(1, 1, 1, 32'h200, 0, 32'h0, 0, 32'h100, 1, 32'hD5D5_D5D5, 32'h100);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h200, 1, 32'h0, 32'h200);

        // redirect with response ready, then wrap past 0xFFFF_FFFC
        step(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h7777, 1, 32'h200, 1, 32'h7777, 32'h200);
        step(1, 0, 0, 0, 1, 32'h13, 1, 32'hFFFF_FFFC, 0, 32'h13, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h33, 1, 32'h0, 0, 32'h33, 32'h0);

        // reset while the request to 0x40 is outstanding
        step(1, 0, 1, 32'h40, 1, 32'h44, 1, 32'h4, 1, 32'h44, 32'h4);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h40, 1, 32'h0, 32'h40);
        step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 32'h55, 1, 32'h0, 0, 32'h55, 32'h0);
        step(1, 0, 0, 0, 1, 32'h66, 1, 32'h4, 0, 32'h66, 32'h4);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
